ex_stage_unit: RTL
==================

# ex_stage_unit

Parametrised execute stage for the five-stage pipeline: operand forwarding, a WIDTH-bit ALU with shifts and signed/unsigned compare, an iterative unsigned multiply/divide unit with HI/LO registers, and the registered EX/MEM output latch. It sits between the ID/EX and EX/MEM boundaries. It raises `stall` upstream while a multi-cycle operation occupies EX.

## Interface
- `WIDTH`, 32, datapath width in bits; must be at least 8 and a power of two.
- `RADDR`, 5, register-address width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `in_valid`  in  1  ID/EX holds a live instruction.
- `flush`  in  1  kill the instruction currently in EX.
- `data1`, `data2`, `imm`  in  WIDTH each  register-file operands and the sign-extended immediate.
- `ex_mem_fwd`, `mem_wb_fwd`  in  WIDTH each  forwarded results.
- `forward_a`, `forward_b`  in  2 each  forwarding selects.
- `alu_src`, `reg_dst`  in  1 each  select `imm` as operand B; select `rd` as the destination register.
- `rt`, `rd`  in  RADDR each  candidate destination registers.
- `alu_op`  in  4  operation code.
- `stall`  out  1  combinational; hold ID/EX and earlier stages.
- `out_valid`  out  1  registered; the EX/MEM latch holds a retired instruction.
- `aluresult`, `rtresult`  out  WIDTH each  registered result and store data.
- `desreg`  out  RADDR  registered destination register.
- `zero`  out  1  registered; set when operand A equals operand B.

## Operation
- Forward select, applied independently to A and B:
  - 00 selects the register operand.
  - 01 selects `mem_wb_fwd`.
  - 10 selects `ex_mem_fwd`.
  - 11 is treated as 00; the output is never X or Z.
- `rtresult` is the forwarded B value. Operand B is `imm` when `alu_src` is set, otherwise the forwarded B value.
- `alu_op` codes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 NOR, 0110 SUB.
  - 0111 SLT, signed compare. 0101 SLTU, unsigned compare. Both produce 1 or 0, zero-extended.
  - 1000 SLL, 1001 SRL, 1010 SRA. Shift A by B[log2(WIDTH)-1:0].
  - 1100 MULTU: {HI,LO} = A×B, unsigned.
  - 1101 DIVU: LO = A/B, HI = A%B.
  - 1110 MFHI, 1111 MFLO: return HI or LO.
  - 1011 returns 0.
- ADD and SUB wrap modulo 2^WIDTH. No overflow detection.
- Divide by zero gives HI = A and LO = all ones, with the same latency as a normal divide.
- FSM states:
  - IDLE: `in_valid` with a MULTU or DIVU code latches A and B, clears the counter, and moves to MUL or DIV.
  - MUL: one shift-add step per cycle for WIDTH cycles, then DONE.
  - DIV: one restoring-divide step per cycle for WIDTH cycles, then DONE.
  - DONE: writes HI/LO and retires the instruction, then returns to IDLE.
- `stall` is 1 while a MULTU/DIVU is in EX and the FSM is not in DONE. This includes the presenting cycle in IDLE.
- The retired MULTU/DIVU has `out_valid` = 1, `aluresult` = 0 and `desreg` = 0, so no register-file write occurs.
- MFHI/MFLO present while MUL or DIV is active stalls until DONE, then reads the freshly written value. This covers back-to-back issue only; the upstream stall normally prevents it.
- `flush`:
  - The next latch gets `out_valid` = 0.
  - An active MUL or DIV aborts to IDLE without writing HI/LO.
  - `stall` drops in the same cycle.
  - `flush` takes priority over every other event.

## Timing
- Reset values: `out_valid`, `aluresult`, `rtresult`, `desreg`, `zero`, HI, LO and the counter are all 0, and the FSM is in IDLE.
- A reset asserted mid-operation aborts immediately and discards HI/LO updates.
- Single-cycle ops: the result is latched at the first rising edge after presentation, so latency is 1.
- MULTU/DIVU:
  - `stall` is high for WIDTH+1 cycles.
  - The instruction retires at edge WIDTH+2.
  - HI/LO are visible to an MFHI/MFLO on the following cycle.
- While `stall` = 1, each edge latches a bubble (`out_valid` = 0). The latched operands are used, so forwarding inputs changing during the stall have no effect.
- `in_valid` = 0 latches a bubble. In that case `aluresult`, `rtresult` and `desreg` hold their previous values.

## Test plan
- Forwarding: data1=5, ex_mem_fwd=9, forward_a=10, data2=3, ADD -> `aluresult` = 12 one cycle later. Repeat with forward_a=11 -> 8.
- Compare and shifts: A=0xFFFFFFFF, B=1. SLT -> 1, SLTU -> 0, SRA by 4 -> 0xFFFFFFFF, SRL by 4 -> 0x0FFFFFFF.
- Multiply: MULTU with A=0xFFFFFFFF and B=2 -> `stall` high 33 cycles. Then MFHI -> 1 and MFLO -> 0xFFFFFFFE.
- Divide: DIVU 100/7 -> LO=14, HI=2. DIVU 100/0 -> LO=0xFFFFFFFF, HI=100.
- Flush and reset: assert `flush` 10 cycles into a MULTU -> `stall` drops, HI/LO unchanged, `out_valid` = 0. Pulse `rst_n` low mid-DIVU -> all outputs 0 and the FSM in IDLE.
- Parametrisation: WIDTH=16 build, MULTU 0x8000×4 -> HI=2, LO=0, `stall` high 17 cycles.

Source files
------------

// File: rtl/ex_stage_unit.sv
// Execute stage: operand forwarding, ALU, iterative multiply/divide with HI/LO
// registers, and the registered EX/MEM output latch.
module ex_stage_unit #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             flush,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [WIDTH-1:0] imm,
  input  logic [WIDTH-1:0] ex_mem_fwd,
  input  logic [WIDTH-1:0] mem_wb_fwd,
  input  logic [1:0]       forward_a,
  input  logic [1:0]       forward_b,
  input  logic             alu_src,
  input  logic             reg_dst,
  input  logic [RADDR-1:0] rt,
  input  logic [RADDR-1:0] rd,
  input  logic [3:0]       alu_op,
  output logic             stall,
  output logic             out_valid,
  output logic [WIDTH-1:0] aluresult,
  output logic [WIDTH-1:0] rtresult,
  output logic [RADDR-1:0] desreg,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);
  localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_NOR   = 4'b0100;
  localparam logic [3:0] OP_SLTU  = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MULTU = 4'b1100;
  localparam logic [3:0] OP_DIVU  = 4'b1101;
  localparam logic [3:0] OP_MFHI  = 4'b1110;
  localparam logic [3:0] OP_MFLO  = 4'b1111;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  // Select 11 falls back to the register operand so the mux output is never X.
  function automatic logic [WIDTH-1:0] fwd_sel(input logic [1:0] sel,
                                               input logic [WIDTH-1:0] reg_v,
                                               input logic [WIDTH-1:0] mw_v,
                                               input logic [WIDTH-1:0] em_v);
    case (sel)
      2'b01:   fwd_sel = mw_v;
      2'b10:   fwd_sel = em_v;
      default: fwd_sel = reg_v;
    endcase
  endfunction

  state_t             r_state;
  state_t             w_next;
  logic [SHW-1:0]     r_cnt;
  logic [WIDTH-1:0]   r_ma;
  logic [WIDTH-1:0]   r_mb;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_fwd_b;
  logic [WIDTH-1:0] w_b;
  logic [SHW-1:0]   w_sh;
  logic [WIDTH-1:0] w_alu;
  logic             w_is_md;
  logic             w_is_mf;
  logic             w_stall;
  logic             w_start;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH:0]   w_div_trial;
  logic [WIDTH-1:0] w_div_rem;
  logic             w_q_bit;

  // Operand selection and single-cycle ALU.
  always_comb begin
    w_a     = fwd_sel(forward_a, data1, mem_wb_fwd, ex_mem_fwd);
    w_fwd_b = fwd_sel(forward_b, data2, mem_wb_fwd, ex_mem_fwd);
    w_b     = alu_src ? imm : w_fwd_b;
    w_sh    = w_b[SHW-1:0];
    w_is_md = (alu_op == OP_MULTU) || (alu_op == OP_DIVU);
    w_is_mf = (alu_op == OP_MFHI) || (alu_op == OP_MFLO);
    case (alu_op)
      OP_AND:  w_alu = w_a & w_b;
      OP_OR:   w_alu = w_a | w_b;
      OP_ADD:  w_alu = w_a + w_b;
      OP_XOR:  w_alu = w_a ^ w_b;
      OP_NOR:  w_alu = ~(w_a | w_b);
      OP_SUB:  w_alu = w_a - w_b;
      OP_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
      OP_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (w_a < w_b)};
      OP_SLL:  w_alu = w_a << w_sh;
      OP_SRL:  w_alu = w_a >> w_sh;
      OP_SRA:  w_alu = WIDTH'($signed(w_a) >>> w_sh);
      OP_MFHI: w_alu = r_hi;
      OP_MFLO: w_alu = r_lo;
      default: w_alu = {WIDTH{1'b0}};
    endcase
  end

  // Shift-add multiply and restoring divide share r_prod: {HI-side, LO-side}.
  always_comb begin
    w_mul_sum   = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                  (r_prod[0] ? {1'b0, r_ma} : {(WIDTH+1){1'b0}});
    w_div_shift = {r_prod[2*WIDTH-1:WIDTH], r_prod[WIDTH-1]};
    w_div_trial = w_div_shift - {1'b0, r_mb};
    w_q_bit     = ~w_div_trial[WIDTH];
    if (w_q_bit) begin
      w_div_rem = w_div_trial[WIDTH-1:0];
    end else begin
      w_div_rem = w_div_shift[WIDTH-1:0];
    end
  end

  // Next-state and stall logic; flush overrides everything.
  always_comb begin
    w_next  = r_state;
    w_stall = 1'b0;
    w_start = 1'b0;
    if (flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && w_is_md) begin
            w_stall = 1'b1;
            w_start = 1'b1;
            w_next  = (alu_op == OP_DIVU) ? S_DIV : S_MUL;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_MUL, S_DIV: begin
          w_stall = 1'b1;
          if (r_cnt == LAST_STEP) begin
            w_next = S_DONE;
          end else begin
            w_next = r_state;
          end
        end
        S_DONE: begin
          // A back-to-back MFHI/MFLO waits one more cycle to see the new HI/LO.
          w_stall = in_valid && w_is_mf;
          w_next  = S_IDLE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign stall = w_stall;

  // FSM state, iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= {SHW{1'b0}};
      r_ma    <= {WIDTH{1'b0}};
      r_mb    <= {WIDTH{1'b0}};
      r_prod  <= {(2*WIDTH){1'b0}};
      r_hi    <= {WIDTH{1'b0}};
      r_lo    <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_next;
      if (flush) begin
        r_cnt <= {SHW{1'b0}};
      end else if (w_start) begin
        r_ma   <= w_a;
        r_mb   <= w_b;
        r_cnt  <= {SHW{1'b0}};
        r_prod <= {{WIDTH{1'b0}}, (alu_op == OP_DIVU) ? w_a : w_b};
      end else if (r_state == S_MUL) begin
        r_prod <= {w_mul_sum, r_prod[WIDTH-1:1]};
        r_cnt  <= r_cnt + SHW'(1);
      end else if (r_state == S_DIV) begin
        r_prod <= {w_div_rem, r_prod[WIDTH-2:0], w_q_bit};
        r_cnt  <= r_cnt + SHW'(1);
      end else if (r_state == S_DONE) begin
        r_hi <= r_prod[2*WIDTH-1:WIDTH];
        r_lo <= r_prod[WIDTH-1:0];
      end else begin
        r_cnt <= r_cnt;
      end
    end
  end

  // EX/MEM latch; bubbles leave the data fields untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      aluresult <= {WIDTH{1'b0}};
      rtresult  <= {WIDTH{1'b0}};
      desreg    <= {RADDR{1'b0}};
      zero      <= 1'b0;
    end else if (flush || w_stall) begin
      out_valid <= 1'b0;
    end else if (r_state == S_DONE) begin
      out_valid <= 1'b1;
      aluresult <= {WIDTH{1'b0}};
      rtresult  <= r_mb;
      desreg    <= {RADDR{1'b0}};
      zero      <= (r_ma == r_mb);
    end else if (in_valid) begin
      out_valid <= 1'b1;
      aluresult <= w_alu;
      rtresult  <= w_fwd_b;
      desreg    <= reg_dst ? rd : rt;
      zero      <= (w_a == w_b);
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule
